// File: rtl/sobel_window_addr_gen.sv
//-----------------------------------------------------------------------------
// sobel_window_addr_gen
//
// Purpose
//   Read-address generator for an image buffer of IMG_W x IMG_H pixels stored
//   row-major (pixel (r,c) lives at r*IMG_W + c). It supports two kinds of
//   pass:
//     * linear scan (mode = 0): every pixel once, addresses 0 .. N-1. This is
//       used for a grayscale pass.
//     * 3x3 window scan (mode = 1): every interior pixel is a window centre,
//       visited in raster order. Each centre emits its nine neighbours in
//       raster order inside the window. This is used for a Sobel pass.
//   Each address is offered as a valid/ready beat. It advances only when the
//   beat is accepted, and it holds steady while downstream stalls.
//
// Ports
//   clk          rising-edge clock for all state
//   rst          synchronous, active-high reset; overrides every other input
//   start        begin a pass; only looked at while IDLE
//   mode         0 = linear scan, 1 = 3x3 window scan; sampled with start
//   ready        downstream accepts addr this cycle
//   addr         current read address
//   valid        addr is meaningful (high in LINEAR and WINDOW)
//   tap          window tap index 0..8; 0 in linear mode
//   last_tap     high with tap 8 in window mode; high on every linear beat
//   center_addr  address of the current window centre (linear: equals addr)
//   busy         high while a pass is in progress
//   done         one-cycle pulse when a pass completes normally
//-----------------------------------------------------------------------------
module sobel_window_addr_gen #(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic              ready,
    output logic [ADDR_W-1:0] addr,
    output logic              valid,
    output logic [3:0]        tap,
    output logic              last_tap,
    output logic [ADDR_W-1:0] center_addr,
    output logic              busy,
    output logic              done
);

    //-------------------------------------------------------------------------
    // Constants. All address arithmetic uses elaboration-time constants and
    // adders, so no multiplier is built.
    //-------------------------------------------------------------------------
    localparam logic [ADDR_W-1:0] ADDR_ZERO  = '0;
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_PIX   = ADDR_W'(IMG_W * IMG_H - 1);

    // Centre (1,1) is the first window centre.
    localparam logic [ADDR_W-1:0] FIRST_CTR  = ADDR_W'(IMG_W + 1);

    // Last centre column and last centre row. Border pixels are never
    // centres.
    localparam logic [ADDR_W-1:0] LAST_COL   = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] LAST_ROW   = ADDR_W'(IMG_H - 2);

    // Inside a window, moving from tap 2 to tap 3 (or from tap 5 to tap 6)
    // drops one image row and returns two columns: + IMG_W - 2.
    localparam logic [ADDR_W-1:0] ROW_WRAP   = ADDR_W'(IMG_W - 2);

    // Moving from centre (r,c) to (r,c+1): the new centre is C+1, and its
    // tap 0 is (C+1) - IMG_W - 1 = C - IMG_W.
    localparam logic [ADDR_W-1:0] NEXT_COL_BACK = ADDR_W'(IMG_W);

    // Moving from the last centre of a row, (r,IMG_W-2), to (r+1,1): the new
    // centre is C+3, and its tap 0 is (C+3) - IMG_W - 1 = C - (IMG_W - 2).
    // C >= IMG_W + 1 always holds, so neither subtraction can wrap.
    localparam logic [ADDR_W-1:0] NEXT_ROW_BACK = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] NEXT_ROW_CTR  = ADDR_W'(3);

    localparam logic [3:0] TAP_LAST = 4'd8;

    //-------------------------------------------------------------------------
    // State
    //-------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LINEAR = 2'd1,
        S_WINDOW = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            state_q,  state_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;    // address being offered
    logic [3:0]        tap_q,    tap_d;     // tap index within the window
    logic [ADDR_W-1:0] center_q, center_d;  // r*IMG_W + c of the current centre
    logic [ADDR_W-1:0] col_q,    col_d;     // centre column c
    logic [ADDR_W-1:0] row_q,    row_d;     // centre row r

    logic in_pass;
    logic accept;
    logic row_wrap_tap;

    assign in_pass = (state_q == S_LINEAR) || (state_q == S_WINDOW);
    assign accept  = in_pass && ready;

    // Taps 2 and 5 end a window row, so the next tap starts one image row
    // lower.
    assign row_wrap_tap = (tap_q == 4'd2) || (tap_q == 4'd5);

    //-------------------------------------------------------------------------
    // Next-state and datapath
    //-------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a value before the case statement.
        // Without this, a path that does not assign it would infer a latch.
        state_d  = state_q;
        addr_d   = addr_q;
        tap_d    = tap_q;
        center_d = center_q;
        col_d    = col_q;
        row_d    = row_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d = ADDR_ZERO;
                    tap_d  = 4'd0;
                    if (mode) begin
                        // Tap 0 of centre (1,1) is pixel (0,0), so addr is 0
                        // in both modes.
                        state_d  = S_WINDOW;
                        center_d = FIRST_CTR;
                        col_d    = ADDR_ONE;
                        row_d    = ADDR_ONE;
                    end else begin
                        state_d  = S_LINEAR;
                        center_d = ADDR_ZERO;
                        col_d    = ADDR_ZERO;
                        row_d    = ADDR_ZERO;
                    end
                end
            end

            S_LINEAR: begin
                if (accept) begin
                    if (addr_q == LAST_PIX) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d = addr_q + ADDR_ONE;
                    end
                end
            end

            S_WINDOW: begin
                if (accept) begin
                    if (tap_q == TAP_LAST) begin
                        tap_d = 4'd0;
                        if (col_q == LAST_COL) begin
                            if (row_q == LAST_ROW) begin
                                state_d = S_DONE;
                            end else begin
                                row_d    = row_q + ADDR_ONE;
                                col_d    = ADDR_ONE;
                                center_d = center_q + NEXT_ROW_CTR;
                                addr_d   = center_q - NEXT_ROW_BACK;
                            end
                        end else begin
                            col_d    = col_q + ADDR_ONE;
                            center_d = center_q + ADDR_ONE;
                            addr_d   = center_q - NEXT_COL_BACK;
                        end
                    end else begin
                        tap_d  = tap_q + 4'd1;
                        addr_d = row_wrap_tap ? (addr_q + ROW_WRAP)
                                              : (addr_q + ADDR_ONE);
                    end
                end
            end

            S_DONE: begin
                // The pass lasts exactly one cycle in DONE. start is not
                // looked at here.
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    //-------------------------------------------------------------------------
    // State register. Reset overrides start, ready and any pass in
    // progress, so an aborted pass never reaches DONE.
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments let every flop sample the values
        // from before the edge, no matter what order the statements are in.
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            tap_q    <= '0;
            center_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            tap_q    <= tap_d;
            center_q <= center_d;
            col_q    <= col_d;
            row_q    <= row_d;
        end
    end

    //-------------------------------------------------------------------------
    // Outputs. They are decoded from registered state only, so they never
    // depend on ready in the same cycle.
    //-------------------------------------------------------------------------
    assign addr        = addr_q;
    assign valid       = in_pass;
    assign busy        = in_pass;
    assign done        = (state_q == S_DONE);
    assign tap         = (state_q == S_WINDOW) ? tap_q : 4'd0;
    assign last_tap    = (state_q == S_LINEAR) ||
                         ((state_q == S_WINDOW) && (tap_q == TAP_LAST));
    assign center_addr = (state_q == S_LINEAR) ? addr_q : center_q;

endmodule

// File: tb/tb_sobel_window_addr_gen.sv
//-----------------------------------------------------------------------------
// tb_sobel_window_addr_gen
//
// Bench for sobel_window_addr_gen with a 4x4 image.
// Expected beats come from a plain-arithmetic model of the scan order.
// Inputs change, and outputs are sampled, on the falling clock edge.
//-----------------------------------------------------------------------------
module tb_sobel_window_addr_gen;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mode;
    logic          ready;
    logic [AW-1:0] addr;
    logic          valid;
    logic [3:0]    tap;
    logic          last_tap;
    logic [AW-1:0] center_addr;
    logic          busy;
    logic          done;

    sobel_window_addr_gen #(
        .IMG_W (W),
        .IMG_H (H),
        .ADDR_W(AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .ready      (ready),
        .addr       (addr),
        .valid      (valid),
        .tap        (tap),
        .last_tap   (last_tap),
        .center_addr(center_addr),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int addr;
        int tap;
        int last;
        int center;
    } beat_t;

    // One table row: a pass mode and a beat index (inputs), plus the address,
    // tap and last_tap expected on that beat (outputs).
    typedef struct {
        bit mode;
        int beat;
        int addr;
        int tap;
        int last;
    } vec_t;

    logic [31:0] got_addr [2][36];
    logic [31:0] got_tap  [2][36];
    logic [31:0] got_last [2][36];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference beat list, computed straight from the scan-order rules.
    task automatic build_model(input bit m, output beat_t q[$]);
        beat_t b;
        q.delete();
        if (!m) begin
            for (int i = 0; i < W * H; i++) begin
                b.addr = i; b.tap = 0; b.last = 1; b.center = i;
                q.push_back(b);
            end
        end else begin
            for (int r = 1; r <= H - 2; r++)
                for (int c = 1; c <= W - 2; c++)
                    for (int k = 0; k < 9; k++) begin
                        b.addr   = (r + k / 3 - 1) * W + (c + k % 3 - 1);
                        b.tap    = k;
                        b.last   = (k == 8) ? 1 : 0;
                        b.center = r * W + c;
                        q.push_back(b);
                    end
        end
    endtask

    // Run one full pass. rdy_mode: 0 = always ready, 1 = random ready,
    // 2 = hold ready low for 3 cycles at addr 6 / tap 4.
    // The task returns at the falling edge where done is seen.
    task automatic run_pass(input bit m, input int rdy_mode, input bit keep_start, input bit record);
        beat_t       exp_q[$];
        int          beats      = 0;
        int          stalls     = 0;
        bit          prev_stall = 0;
        bit          finished   = 0;
        logic [31:0] h_addr, h_tap, h_last, h_ctr;
        build_model(m, exp_q);

        @(negedge clk);
        check("idle_done_low", done, 0);
        check("idle_busy_low", busy, 0);
        start = 1'b1; mode = m; ready = 1'b1;
        @(negedge clk);
        start = keep_start;
        check("first_beat_valid", valid, 1);

        for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (done) begin
                check("beats_at_done", beats, exp_q.size());
                check("valid_at_done", valid, 0);
                check("busy_at_done", busy, 0);
                finished = 1;
            end else if (valid) begin
                if (prev_stall) begin
                    check("hold_addr", addr, h_addr);
                    check("hold_tap", tap, h_tap);
                    check("hold_last", last_tap, h_last);
                    check("hold_center", center_addr, h_ctr);
                end
                case (rdy_mode)
                    0:       ready = 1'b1;
                    1:       ready = ($urandom_range(0, 3) != 0);
                    default: ready = !(addr == 6 && tap == 4 && stalls < 3);
                endcase
                if (!ready) stalls++;
                if (ready) begin
                    if (beats < exp_q.size()) begin
                        check("beat_addr", addr, exp_q[beats].addr);
                        check("beat_tap", tap, exp_q[beats].tap);
                        check("beat_last", last_tap, exp_q[beats].last);
                        check("beat_center", center_addr, exp_q[beats].center);
                        check("beat_busy", busy, 1);
                        if (record && beats < 36) begin
                            got_addr[m][beats] = addr;
                            got_tap[m][beats]  = tap;
                            got_last[m][beats] = last_tap;
                        end
                    end else begin
                        check("extra_beat", beats, exp_q.size());
                    end
                    beats++;
                end
                prev_stall = !ready;
                h_addr = addr; h_tap = tap; h_last = last_tap; h_ctr = center_addr;
            end else begin
                check("valid_gap", valid, 1);
            end
        end
        if (!finished) check("pass_timeout", finished, 1);
        if (rdy_mode == 2) check("stall_cycles", stalls, 3);
    endtask

    vec_t vt[12];

    initial begin
        int done_seen;
        int beats;
        bit found;

        vt[0]  = '{0, 0, 0, 0, 1};
        vt[1]  = '{0, 7, 7, 0, 1};
        vt[2]  = '{0, 15, 15, 0, 1};
        vt[3]  = '{1, 0, 0, 0, 0};
        vt[4]  = '{1, 4, 5, 4, 0};
        vt[5]  = '{1, 8, 10, 8, 1};
        vt[6]  = '{1, 9, 1, 0, 0};
        vt[7]  = '{1, 17, 11, 8, 1};
        vt[8]  = '{1, 18, 4, 0, 0};
        vt[9]  = '{1, 26, 14, 8, 1};
        vt[10] = '{1, 27, 5, 0, 0};
        vt[11] = '{1, 35, 15, 8, 1};

        rst = 1'b1; start = 1'b0; mode = 1'b0; ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", valid, 0);
        check("rst_addr", addr, 0);
        check("rst_tap", tap, 0);
        check("rst_last", last_tap, 0);
        check("rst_center", center_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;

        // Linear pass, then a window pass started in the first IDLE cycle.
        run_pass(0, 0, 0, 1);
        run_pass(1, 0, 0, 1);

        for (int i = 0; i < 12; i++) begin
            check($sformatf("vec%0d_addr", i), got_addr[vt[i].mode][vt[i].beat], vt[i].addr);
            check($sformatf("vec%0d_tap", i), got_tap[vt[i].mode][vt[i].beat], vt[i].tap);
            check($sformatf("vec%0d_last", i), got_last[vt[i].mode][vt[i].beat], vt[i].last);
        end

        // Three-cycle stall at tap 4 of centre 6.
        run_pass(1, 2, 0, 0);

        // Reset while the linear pass is at addr 7.
        @(negedge clk);
        start = 1'b1; mode = 1'b0; ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (valid && addr == 7) found = 1;
            else @(negedge clk);
        end
        check("abort_reached_7", found, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_valid", valid, 0);
        check("abort_addr", addr, 0);
        check("abort_busy", busy, 0);
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        run_pass(0, 0, 0, 0);

        // Hold start high through a whole linear pass.
        run_pass(0, 0, 1, 0);
        @(negedge clk);
        check("held_start_idle_valid", valid, 0);
        check("held_start_idle_done", done, 0);
        @(negedge clk);
        check("held_start_relaunch_valid", valid, 1);
        check("held_start_relaunch_addr", addr, 0);
        start = 1'b0;
        ready = 1'b1;
        beats = 0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (done) found = 1;
            else begin
                if (valid) beats++;
                @(negedge clk);
            end
        end
        check("held_start_second_done", found, 1);
        check("held_start_second_beats", beats, 16);

        // Random passes with random back-pressure.
        for (int i = 0; i < 8; i++) begin
            run_pass(1'($urandom_range(0, 1)), 1, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
